// File: rtl/types_pkg.sv
// Shared types for the dispatch stage: decoded instruction beats, the
// tagged dispatch payload and the reservation-station route.
package types_pkg;

   localparam int ROB_DEPTH_DEFAULT = 16;
   localparam int TAG_W             = $clog2(ROB_DEPTH_DEFAULT);

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [3:0]  alu_op;
      logic [6:0]  opcode;
      logic        fu_mem;
      logic        fu_alu;
   } decode_data;

   typedef struct packed {
      decode_data       dec;
      logic [TAG_W-1:0] rob_tag;
   } dispatch_t;

   typedef enum logic {
      ROUTE_ALU = 1'b0,
      ROUTE_MEM = 1'b1
   } route_e;

   // Memory ops win even when fu_alu is also set; anything else goes to the ALU.
   function automatic route_e route_of(input decode_data d);
      return d.fu_mem ? ROUTE_MEM : ROUTE_ALU;
   endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Generic 2-entry valid/ready FIFO with a synchronous flush.
// in_ready depends only on registered occupancy, never on out_ready.
module skid_fifo2 #(
   parameter type T = logic [7:0]
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);

   logic [1:0] count_reg;
   logic       wr_ptr_reg;
   logic       rd_ptr_reg;
   logic       push;
   logic       pop;

   assign in_ready  = (count_reg != 2'd2) && !flush;
   assign out_valid = (count_reg != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;

   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      T entry_reg;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            entry_reg <= '0;
         else if (push && (wr_ptr_reg == 1'(gi)))
            entry_reg <= in_data;
      end
   end

   assign out_data = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg  <= 2'd0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
      end else if (flush) begin
         count_reg  <= 2'd0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)
            rd_ptr_reg <= ~rd_ptr_reg;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/dispatch_ctrl.sv
// In-order dispatch from Decode to the ALU / memory reservation stations:
// ROB tag allocation, ROB occupancy tracking, flush handling, stall counter.
module dispatch_ctrl
   import types_pkg::*;
#(
   parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dec_valid,
   output logic             dec_ready,
   input  decode_data       dec_data,
   output logic             alu_valid,
   input  logic             alu_ready,
   output logic             mem_valid,
   input  logic             mem_ready,
   output dispatch_t        disp_data,
   output logic             rob_alloc,
   input  logic             commit_valid,
   input  logic             flush,
   output logic [TAG_W:0]   rob_count,
   output logic [31:0]      stall_cycles
);

   localparam logic [TAG_W:0]   ROB_FULL = (TAG_W + 1)'(ROB_DEPTH);
   localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(ROB_DEPTH - 1);

   // Explicit wrap keeps tags correct if ROB_DEPTH is below 2**TAG_W.
   function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] t);
      return (t == TAG_LAST) ? '0 : t + 1'b1;
   endfunction

   logic             head_valid;
   decode_data       head_dec;
   route_e           route;
   logic             can_go;
   logic             fire;
   logic             commit;
   logic [TAG_W-1:0] head_ptr_reg;
   logic [TAG_W-1:0] head_ptr_next;
   logic [TAG_W-1:0] tail_reg;
   logic [TAG_W:0]   rob_count_reg;
   logic [31:0]      stall_reg;

   skid_fifo2 #(
      .T (decode_data)
   ) u_skid (
      .clk       (clk),
      .rst_n     (reset),
      .flush     (flush),
      .in_valid  (dec_valid),
      .in_ready  (dec_ready),
      .in_data   (dec_data),
      .out_valid (head_valid),
      .out_ready (fire),
      .out_data  (head_dec)
   );

   assign route     = route_of(head_dec);
   assign can_go    = head_valid && (rob_count_reg < ROB_FULL) && !flush;
   assign alu_valid = can_go && (route == ROUTE_ALU);
   assign mem_valid = can_go && (route == ROUTE_MEM);
   assign fire      = (alu_valid && alu_ready) || (mem_valid && mem_ready);
   assign rob_alloc = fire;

   assign disp_data.dec     = head_dec;
   assign disp_data.rob_tag = tail_reg;

   assign commit        = commit_valid && (rob_count_reg != '0);
   assign head_ptr_next = commit ? tag_inc(head_ptr_reg) : head_ptr_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_ptr_reg  <= '0;
         tail_reg      <= '0;
         rob_count_reg <= '0;
      end else if (flush) begin
         // Everything uncommitted is squashed; the ROB restarts at its head.
         head_ptr_reg  <= head_ptr_next;
         tail_reg      <= head_ptr_next;
         rob_count_reg <= '0;
      end else begin
         head_ptr_reg <= head_ptr_next;
         if (fire)
            tail_reg <= tag_inc(tail_reg);
         case ({fire, commit})
            2'b10:   rob_count_reg <= rob_count_reg + 1'b1;
            2'b01:   rob_count_reg <= rob_count_reg - 1'b1;
            default: rob_count_reg <= rob_count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_reg <= '0;
      else if (head_valid && !flush && !fire && (stall_reg != '1))
         stall_reg <= stall_reg + 32'd1;
   end

   assign rob_count    = rob_count_reg;
   assign stall_cycles = stall_reg;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_dispatch_ctrl;
   import types_pkg::*;

   logic        clk;
   logic        reset;
   logic        dec_valid;
   logic        dec_ready;
   decode_data  dec_data;
   logic        alu_valid;
   logic        alu_ready;
   logic        mem_valid;
   logic        mem_ready;
   dispatch_t   disp_data;
   logic        rob_alloc;
   logic        commit_valid;
   logic        flush;
   logic [4:0]  rob_count;
   logic [31:0] stall_cycles;

   int total = 0;
   int bad   = 0;

   decode_data add_d, lw_d, addi_d, beat_d;
   dispatch_t  zero_disp;
   logic [3:0] exp_tag;

   dispatch_ctrl #(.ROB_DEPTH(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .dec_valid    (dec_valid),
      .dec_ready    (dec_ready),
      .dec_data     (dec_data),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .disp_data    (disp_data),
      .rob_alloc    (rob_alloc),
      .commit_valid (commit_valid),
      .flush        (flush),
      .rob_count    (rob_count),
      .stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic decode_data mk(input logic [31:0] pc, input logic [31:0] ins,
                                     input logic [31:0] imm, input logic fm, input logic fa);
      decode_data d;
      d.pc     = pc;
      d.rs1    = ins[19:15];
      d.rs2    = ins[24:20];
      d.rd     = ins[11:7];
      d.imm    = imm;
      d.alu_op = 4'h0;
      d.opcode = ins[6:0];
      d.fu_mem = fm;
      d.fu_alu = fa;
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b0;
      dec_valid    = 1'b0;
      dec_data     = '0;
      alu_ready    = 1'b0;
      mem_ready    = 1'b0;
      commit_valid = 1'b0;
      flush        = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      dec_valid = 1'b0; dec_data = '0; alu_ready = 1'b1; mem_ready = 1'b1;
      commit_valid = 1'b0; flush = 1'b0;
      tick();
      tick();
      total++; if (alu_valid !== 1'b0) begin bad++; $display("FAIL reset_alu_valid got=%b exp=0", alu_valid); end
      total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
      total++; if (rob_alloc !== 1'b0) begin bad++; $display("FAIL reset_rob_alloc got=%b exp=0", rob_alloc); end
      total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL reset_dec_ready got=%b exp=1", dec_ready); end
      total++; if (disp_data !== zero_disp) begin bad++; $display("FAIL reset_disp_data got=%h exp=0", disp_data); end
      total++; if (rob_count !== 5'd0) begin bad++; $display("FAIL reset_rob_count got=%0d exp=0", rob_count); end
      total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
      $display("test_reset checked");
   endtask

   task automatic test_add();
      do_reset();
      alu_ready = 1'b1; mem_ready = 1'b1;
      dec_valid = 1'b1; dec_data = add_d;
      #1;
      total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL add_dec_ready got=%b exp=1", dec_ready); end
      total++; if (alu_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid got=%b exp=0", alu_valid); end
      tick();
      dec_valid = 1'b0;
      #1;
      total++; if (alu_valid !== 1'b1) begin bad++; $display("FAIL add_alu_valid got=%b exp=1", alu_valid); end
      total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL add_mem_valid got=%b exp=0", mem_valid); end
      total++; if (rob_alloc !== 1'b1) begin bad++; $display("FAIL add_rob_alloc got=%b exp=1", rob_alloc); end
      total++; if (disp_data.rob_tag !== 4'd0) begin bad++; $display("FAIL add_tag got=%0d exp=0", disp_data.rob_tag); end
      total++; if (disp_data.dec !== add_d) begin bad++; $display("FAIL add_payload got=%h exp=%h", disp_data.dec, add_d); end
      tick();
      total++; if (rob_count !== 5'd1) begin bad++; $display("FAIL add_rob_count got=%0d exp=1", rob_count); end
      total++; if (rob_alloc !== 1'b0) begin bad++; $display("FAIL add_alloc_pulse got=%b exp=0", rob_alloc); end
      total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL add_stall got=%0d exp=0", stall_cycles); end
      $display("test_add checked");
   endtask

   task automatic test_mem_stall();
      do_reset();
      alu_ready = 1'b1; mem_ready = 1'b0;
      dec_valid = 1'b1; dec_data = lw_d;
      tick();
      dec_data = addi_d;
      #1;
      total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL stall_mem_valid got=%b exp=1", mem_valid); end
      total++; if (alu_valid !== 1'b0) begin bad++; $display("FAIL stall_alu_valid got=%b exp=0", alu_valid); end
      total++; if (disp_data.rob_tag !== 4'd0) begin bad++; $display("FAIL stall_tag got=%0d exp=0", disp_data.rob_tag); end
      total++; if (rob_alloc !== 1'b0) begin bad++; $display("FAIL stall_alloc got=%b exp=0", rob_alloc); end
      tick();
      dec_valid = 1'b0;
      #1;
      total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL stall_dec_ready got=%b exp=0", dec_ready); end
      total++; if (alu_valid !== 1'b0) begin bad++; $display("FAIL stall_no_bypass got=%b exp=0", alu_valid); end
      total++; if (disp_data.dec.pc !== lw_d.pc) begin bad++; $display("FAIL stall_head_pc got=%h exp=%h", disp_data.dec.pc, lw_d.pc); end
      tick();
      total++; if (stall_cycles !== 32'd2) begin bad++; $display("FAIL stall_count2 got=%0d exp=2", stall_cycles); end
      tick();
      mem_ready = 1'b1;
      #1;
      total++; if (stall_cycles !== 32'd3) begin bad++; $display("FAIL stall_count3 got=%0d exp=3", stall_cycles); end
      total++; if ({mem_valid, rob_alloc} !== 2'b11) begin bad++; $display("FAIL stall_lw_fire got=%b exp=11", {mem_valid, rob_alloc}); end
      total++; if (disp_data.rob_tag !== 4'd0) begin bad++; $display("FAIL stall_lw_tag got=%0d exp=0", disp_data.rob_tag); end
      tick();
      mem_ready = 1'b0;
      #1;
      total++; if ({alu_valid, mem_valid, rob_alloc} !== 3'b101) begin bad++; $display("FAIL stall_addi_fire got=%b exp=101", {alu_valid, mem_valid, rob_alloc}); end
      total++; if (disp_data.rob_tag !== 4'd1) begin bad++; $display("FAIL stall_addi_tag got=%0d exp=1", disp_data.rob_tag); end
      total++; if (disp_data.dec !== addi_d) begin bad++; $display("FAIL stall_addi_payload got=%h exp=%h", disp_data.dec, addi_d); end
      tick();
      total++; if (rob_count !== 5'd2) begin bad++; $display("FAIL stall_rob_count got=%0d exp=2", rob_count); end
      total++; if (stall_cycles !== 32'd3) begin bad++; $display("FAIL stall_count_final got=%0d exp=3", stall_cycles); end
      $display("test_mem_stall checked");
   endtask

   task automatic test_rob_full();
      do_reset();
      alu_ready = 1'b1; mem_ready = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         dec_valid = 1'b1;
         dec_data  = mk(32'(i * 4), 32'h005201B3, 32'h0, 1'b0, 1'b1);
         #1;
         if (i > 0) begin
            exp_tag = 4'(i - 1);
            total++;
            if ({alu_valid, disp_data.rob_tag} !== {1'b1, exp_tag}) begin
               bad++; $display("FAIL full_fill_%0d got=%b/%0d exp=1/%0d", i, alu_valid, disp_data.rob_tag, exp_tag);
            end
         end
         tick();
      end
      dec_valid = 1'b0;
      #1;
      total++; if (rob_count !== 5'd16) begin bad++; $display("FAIL full_rob_count got=%0d exp=16", rob_count); end
      total++; if (alu_valid !== 1'b0) begin bad++; $display("FAIL full_held got=%b exp=0", alu_valid); end
      tick();
      commit_valid = 1'b1;
      #1;
      total++; if (alu_valid !== 1'b0) begin bad++; $display("FAIL full_held_commit got=%b exp=0", alu_valid); end
      tick();
      commit_valid = 1'b0;
      #1;
      total++; if ({alu_valid, rob_alloc} !== 2'b11) begin bad++; $display("FAIL full_release got=%b exp=11", {alu_valid, rob_alloc}); end
      total++; if (disp_data.rob_tag !== 4'd0) begin bad++; $display("FAIL full_wrap_tag got=%0d exp=0", disp_data.rob_tag); end
      total++; if (disp_data.dec.pc !== 32'd64) begin bad++; $display("FAIL full_17th_pc got=%h exp=40", disp_data.dec.pc); end
      tick();
      total++; if (rob_count !== 5'd16) begin bad++; $display("FAIL full_rob_count_after got=%0d exp=16", rob_count); end
      $display("test_rob_full checked");
   endtask

   // Continues from the full-ROB state left by test_rob_full (tail = 1).
   task automatic test_back_to_back();
      commit_valid = 1'b1;
      dec_valid    = 1'b1;
      dec_data     = mk(32'h100, 32'h005201B3, 32'h0, 1'b0, 1'b1);
      tick();
      for (int j = 0; j < 20; j++) begin
         dec_data = mk(32'h104 + 32'(j * 4), 32'h005201B3, 32'h0, 1'b0, 1'b1);
         #1;
         exp_tag = 4'((1 + j) % 16);
         total++;
         if ({alu_valid, rob_alloc, disp_data.rob_tag, rob_count} !== {2'b11, exp_tag, 5'd15}) begin
            bad++; $display("FAIL b2b_%0d got=v%b a%b t%0d c%0d exp=v1 a1 t%0d c15",
                            j, alu_valid, rob_alloc, disp_data.rob_tag, rob_count, exp_tag);
         end
         tick();
      end
      dec_valid = 1'b0;
      commit_valid = 1'b0;
      tick();
      $display("test_back_to_back checked");
   endtask

   task automatic test_flush();
      do_reset();
      alu_ready = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         dec_valid = 1'b1;
         dec_data  = mk(32'h200 + 32'(i * 4), 32'h005201B3, 32'h0, 1'b0, 1'b1);
         tick();
      end
      alu_ready = 1'b0;
      dec_data  = mk(32'h218, 32'h005201B3, 32'h0, 1'b0, 1'b1);
      tick();
      dec_valid = 1'b0;
      #1;
      total++; if (rob_count !== 5'd5) begin bad++; $display("FAIL flush_pre_count got=%0d exp=5", rob_count); end
      total++; if ({dec_ready, alu_valid} !== 2'b01) begin bad++; $display("FAIL flush_pre_state got=%b exp=01", {dec_ready, alu_valid}); end
      flush = 1'b1; commit_valid = 1'b1; alu_ready = 1'b1;
      #1;
      total++; if ({alu_valid, mem_valid, dec_ready, rob_alloc} !== 4'b0000) begin
         bad++; $display("FAIL flush_cycle got=%b exp=0000", {alu_valid, mem_valid, dec_ready, rob_alloc});
      end
      tick();
      flush = 1'b0; commit_valid = 1'b0;
      #1;
      total++; if (rob_count !== 5'd0) begin bad++; $display("FAIL flush_rob_count got=%0d exp=0", rob_count); end
      total++; if ({dec_ready, alu_valid} !== 2'b10) begin bad++; $display("FAIL flush_empty got=%b exp=10", {dec_ready, alu_valid}); end
      total++; if (disp_data.rob_tag !== 4'd1) begin bad++; $display("FAIL flush_tail got=%0d exp=1", disp_data.rob_tag); end
      dec_valid = 1'b1; dec_data = add_d;
      tick();
      dec_valid = 1'b0;
      #1;
      total++; if ({alu_valid, disp_data.rob_tag} !== {1'b1, 4'd1}) begin
         bad++; $display("FAIL flush_redispatch got=%b/%0d exp=1/1", alu_valid, disp_data.rob_tag);
      end
      tick();
      $display("test_flush checked");
   endtask

   task automatic test_route();
      do_reset();
      alu_ready = 1'b1; mem_ready = 1'b1;
      dec_valid = 1'b1;
      dec_data  = mk(32'h300, 32'h00000013, 32'h0, 1'b0, 1'b0);
      tick();
      dec_data  = mk(32'h304, 32'h00A12023, 32'h0, 1'b1, 1'b1);
      #1;
      total++; if ({alu_valid, mem_valid} !== 2'b10) begin bad++; $display("FAIL route_none got=%b exp=10", {alu_valid, mem_valid}); end
      tick();
      dec_valid = 1'b0;
      #1;
      total++; if ({alu_valid, mem_valid} !== 2'b01) begin bad++; $display("FAIL route_both got=%b exp=01", {alu_valid, mem_valid}); end
      total++; if (disp_data.rob_tag !== 4'd1) begin bad++; $display("FAIL route_tag got=%0d exp=1", disp_data.rob_tag); end
      tick();
      $display("test_route checked");
   endtask

   task automatic test_reset_mid();
      do_reset();
      alu_ready = 1'b1; mem_ready = 1'b0;
      dec_valid = 1'b1; dec_data = add_d;
      tick();
      dec_data = lw_d;
      tick();
      dec_valid = 1'b0;
      #1;
      total++; if ({mem_valid, disp_data.rob_tag} !== {1'b1, 4'd1}) begin
         bad++; $display("FAIL rmid_pre got=%b/%0d exp=1/1", mem_valid, disp_data.rob_tag);
      end
      reset = 1'b0;
      #1;
      total++; if ({alu_valid, mem_valid, rob_alloc} !== 3'b000) begin
         bad++; $display("FAIL rmid_valids got=%b exp=000", {alu_valid, mem_valid, rob_alloc});
      end
      total++; if (rob_count !== 5'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", rob_count); end
      tick();
      tick();
      reset = 1'b1; mem_ready = 1'b1;
      dec_valid = 1'b1; dec_data = add_d;
      tick();
      dec_valid = 1'b0;
      #1;
      total++; if ({alu_valid, disp_data.rob_tag} !== {1'b1, 4'd0}) begin
         bad++; $display("FAIL rmid_first_tag got=%b/%0d exp=1/0", alu_valid, disp_data.rob_tag);
      end
      tick();
      total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL rmid_stall got=%0d exp=0", stall_cycles); end
      $display("test_reset_mid checked");
   endtask

   initial begin
      zero_disp = '0;
      add_d  = mk(32'h0000_1000, 32'h005201B3, 32'h0000_0000, 1'b0, 1'b1);
      lw_d   = mk(32'h0000_1004, 32'hFF042503, 32'hFFFF_FFF0, 1'b1, 1'b0);
      addi_d = mk(32'h0000_1008, 32'hFFF30293, 32'hFFFF_FFFF, 1'b0, 1'b1);
      test_reset();
      test_add();
      test_mem_stall();
      test_rob_full();
      test_back_to_back();
      test_flush();
      test_route();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- Sits between Decode and the back end of the out-of-order RISC-V core.
- Accepts decode_data beats from Decode over a valid/ready handshake and holds them in a 2-entry skid buffer.
- Allocates a ROB tag to each instruction in program order and steers it to the ALU or memory reservation station.
- Tracks ROB occupancy from commits, honours full-pipeline flushes, and keeps a dispatch-stall performance counter.

Parameters:
- ROB_DEPTH, 16, number of ROB entries; power of two ≥ 2.
- TAG_W, $clog2(ROB_DEPTH), ROB tag width (derived; not overridden).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- dec_valid  in  1  Decode output beat valid.
- dec_ready  out  1  dispatch_ctrl can accept a beat.
- dec_data  in  decode_data  decoded instruction (pc, rs1, rs2, rd, imm, ALUOp, Opcode, fu_mem, fu_alu).
- alu_valid  out  1  dispatch to ALU RS valid.
- alu_ready  in  1  ALU RS has a free slot.
- mem_valid  out  1  dispatch to memory RS valid.
- mem_ready  in  1  memory RS has a free slot.
- disp_data  out  dispatch_t  head instruction plus rob_tag; shared by both RS ports.
- rob_alloc  out  1  one-cycle pulse; ROB entry disp_data.rob_tag allocated.
- commit_valid  in  1  ROB retired its head entry this cycle.
- flush  in  1  mispredict/exception; squash everything not yet committed.
- rob_count  out  TAG_W+1  occupied ROB entries.
- stall_cycles  out  32  performance counter.

Behaviour:
- Reset values: buffer empty, tail = head = 0, rob_count = 0, stall_cycles = 0. Therefore alu_valid = 0, mem_valid = 0, rob_alloc = 0, dec_ready = 1, disp_data = 0.
- Skid buffer is 2 entries, FIFO order.
- Enqueue when dec_valid & dec_ready.
- dec_ready = (occupancy < 2) & ~flush; it is a combinational function of registered occupancy only.
- Routing of the head entry: if fu_mem = 1 (loads/stores, even with fu_alu = 1), route to mem. Otherwise route to alu; this includes fu_alu = 0 & fu_mem = 0.
- can_go = head valid & (rob_count < ROB_DEPTH) & ~flush.
- alu_valid = can_go & route_alu; mem_valid = can_go & route_mem.
- Valid must never depend on the matching ready.
- Dispatch fires on (alu_valid & alu_ready) | (mem_valid & mem_ready). On fire:
  - pop head;
  - rob_alloc = 1;
  - tail increments modulo ROB_DEPTH.
- disp_data.rob_tag = tail at all times.
- At most one dispatch per cycle, in strict program order. A blocked mem head blocks a following ALU instruction; there is no bypass.
- Latency: a beat accepted at cycle N can dispatch at cycle N+1 at the earliest. Sustained throughput is 1/cycle with both readys high.
- Same-cycle enqueue and dispatch are both honoured, including when occupancy is 2 at the start of the cycle (dec_ready = 0 then, so no enqueue).
- Commit: when commit_valid & rob_count > 0, head increments modulo ROB_DEPTH. commit_valid with rob_count = 0 is ignored.
- rob_count register update: +1 on dispatch only, −1 on commit only, unchanged on both or neither.
- ROB full: rob_count == ROB_DEPTH. Both valids stay low and the buffer holds. A commit in that cycle allows dispatch the next cycle.
- Tag wrap: the tag after ROB_DEPTH−1 is 0.
- Flush has priority over enqueue and dispatch. In a flush cycle:
  - valids = 0, dec_ready = 0, no rob_alloc;
  - next cycle: buffer empty, tail = head_next, rob_count = 0.
  - head_next includes a same-cycle commit.
- stall_cycles increments (saturating at 2^32−1) in any cycle where head valid & ~flush & no dispatch fires.
- Reset assertion mid-operation clears all state immediately; in-flight beats are dropped.

Decomposition:
- types_pkg gains:
  - typedef dispatch_t (decode_data dec; logic [TAG_W-1:0] rob_tag);
  - localparam ROB_DEPTH_DEFAULT = 16;
  - enum route_e {ROUTE_ALU, ROUTE_MEM}.
- One sub-module: skid_fifo2, a generic 2-entry valid/ready FIFO with flush, parameterised on payload type. dispatch_ctrl holds the tag, occupancy and stall logic around it.

Test Plan:
- Reset, then ADD (0x005201B3) with alu_ready = 1 → alu_valid at cycle 1, rob_tag = 0, rob_alloc pulse, rob_count = 1, mem_valid = 0.
- LW (0xFF042503) followed by ADDI (0xFFF30293), mem_ready = 0 for 3 cycles → mem_valid held with tag 0. ADDI is not dispatched; dec_ready drops once 2 are buffered; stall_cycles = 3. Then mem_ready = 1 → LW tag 0, ADDI tag 1 on the next cycle.
- Dispatch 16 ADDs with no commits → rob_count = 16 and the 17th is held. One commit_valid → the 17th dispatches with tag 0 (wrap), rob_count stays 16.
- Simultaneous dispatch and commit each cycle for 20 cycles → rob_count constant; tags run 1..15, 0..4.
- With 2 buffered and rob_count = 5, assert flush together with commit_valid → next cycle buffer empty, rob_count = 0, tail = head = 1, dec_ready = 1, no rob_alloc during the flush.
- Pull reset low while mem_valid = 1 → all valids 0 immediately; after release, the first dispatch has tag 0 and stall_cycles = 0.
